button_event_arbiter: RTL and testbench

//   Debounces N_BTN raw push-button inputs and turns each debounced edge into
//   a press or release event. A round-robin arbiter merges all events onto a

---
 rtl/button_event_arbiter.sv | 270 +++++++++++++++++++++++++++
 tb/tb_button_event_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : button_event_arbiter
//  Purpose  : Debounces N_BTN raw push-button levels, converts each debounced
//             edge into a press/release event (plus an optional long-press
//             event) and merges all events onto one valid/ready channel using
//             a round-robin arbiter.
//
//  Ports    : clk        in   system clock
//             rst        in   synchronous reset, active-high
//             btn_raw    in   asynchronous raw button levels, 1 = pressed
//             btn_state  out  debounced level per button
//             evt_valid  out  event offered
//             evt_ready  in   consumer accepts event
//             evt_id     out  index of the button that produced the event
//             evt_type   out  00 press, 01 release, 10 long-press
//             evt_drop   out  1-cycle pulse: a pending event was overwritten
//
//  Options  : LONGPRESS_EN - when defined, each button also carries a hold
//             counter that emits one long-press event per press after
//             LONG_CYCLES cycles of continuous debounced press. When not
//             defined, no hold counters exist and type 10 is never produced.
//
//  Revision : 1.0  initial release
// ============================================================================
module button_event_arbiter #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn_raw,
    output logic [N_BTN-1:0]         btn_state,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic [1:0]               evt_type,
    output logic                     evt_drop
);

    localparam int                  c_ID_W    = $clog2(N_BTN);
    localparam logic [c_ID_W-1:0]   c_ID_LAST = c_ID_W'(N_BTN - 1);

    localparam int                  c_DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_W-1:0]   c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DB_W-1:0]   c_DB_ONE  = c_DB_W'(1);

    localparam logic [1:0]          c_EVT_PRESS   = 2'b00;
    localparam logic [1:0]          c_EVT_RELEASE = 2'b01;
    localparam logic [1:0]          c_EVT_LONG    = 2'b10;

    localparam logic                c_ST_IDLE  = 1'b0;
    localparam logic                c_ST_OFFER = 1'b1;

    // ------------------------------------------------------------------------
    // Two-flop synchronizers for the asynchronous button inputs
    // ------------------------------------------------------------------------
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Per-button pending slots exported to the arbiter, and the arbiter's
    // latch strobes fed back to the slots.
    logic [N_BTN-1:0]   w_pend_flag;
    logic [2*N_BTN-1:0] w_pend_type;
    logic [N_BTN-1:0]   w_drop_vec;
    logic [N_BTN-1:0]   w_latch_vec;

    // ------------------------------------------------------------------------
    // Per-button debounce, edge detection, optional hold timer, pending slot
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        logic [c_DB_W-1:0] r_db_cnt;
        logic              r_btn;
        logic              r_btn_d;
        logic              r_slot_flag;
        logic [1:0]        r_slot_type;
        logic              w_edge_load;
        logic              w_long_load;
        logic              w_load;
        logic [1:0]        w_load_type;

        // The counter only runs while the synced level disagrees with the
        // debounced level; any agreement (a bounce back) restarts it.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_db_cnt <= '0;
                r_btn    <= 1'b0;
                r_btn_d  <= 1'b0;
            end else begin
                r_btn_d <= r_btn;
                if (r_sync2[gi] == r_btn) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == c_DB_LAST) begin
                    r_btn    <= r_sync2[gi];
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + c_DB_ONE;
                end
            end
        end

        // The event is loaded one cycle after the debounced level moves, so
        // it is offered two cycles after btn_state changes.
        assign w_edge_load = r_btn ^ r_btn_d;

`ifdef LONGPRESS_EN
        localparam int                c_LG_W    = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
        localparam logic [c_LG_W-1:0] c_LG_LAST = c_LG_W'(LONG_CYCLES - 1);
        localparam logic [c_LG_W-1:0] c_LG_ONE  = c_LG_W'(1);

        logic [c_LG_W-1:0] r_hold_cnt;
        logic              r_long_done;

        // r_long_done limits the long-press event to once per press; both
        // are cleared whenever the button is released.
        always_ff @(posedge clk) begin
            if (rst || !r_btn) begin
                r_hold_cnt  <= '0;
                r_long_done <= 1'b0;
            end else if (!r_long_done) begin
                if (r_hold_cnt == c_LG_LAST) begin
                    r_hold_cnt  <= '0;
                    r_long_done <= 1'b1;
                end else begin
                    r_hold_cnt <= r_hold_cnt + c_LG_ONE;
                end
            end
        end

        assign w_long_load = r_btn && !r_long_done && (r_hold_cnt == c_LG_LAST);
`else
        // Long-press disabled; the parameter only keeps the interface uniform
        // and this comparison is constant false for any legal setting.
        assign w_long_load = (LONG_CYCLES < 0);
`endif

        // Edge and long-press loads can never land in the same cycle (the
        // long-press fires only while the level is steady), so the edge
        // simply takes precedence.
        assign w_load      = w_edge_load | w_long_load;
        assign w_load_type = w_edge_load ? (r_btn ? c_EVT_PRESS : c_EVT_RELEASE) : c_EVT_LONG;

        // A load in the same cycle the arbiter latches this slot keeps the
        // new event pending; the latch already took the old one, so nothing
        // is lost and no drop is reported.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_slot_flag <= 1'b0;
                r_slot_type <= 2'b00;
            end else if (w_load) begin
                r_slot_flag <= 1'b1;
                r_slot_type <= w_load_type;
            end else if (w_latch_vec[gi]) begin
                r_slot_flag <= 1'b0;
            end
        end

        assign w_drop_vec[gi]         = w_load && r_slot_flag && !w_latch_vec[gi];
        assign w_pend_flag[gi]        = r_slot_flag;
        assign w_pend_type[2*gi +: 2] = r_slot_type;
        assign btn_state[gi]          = r_btn;
    end

    // ------------------------------------------------------------------------
    // Round-robin selection: rotate the pending flags so the pointer sits at
    // bit 0, take the lowest set bit, then rotate the index back.
    // ------------------------------------------------------------------------
    logic              r_fsm;
    logic [c_ID_W-1:0] r_ptr;
    logic [c_ID_W-1:0] r_evt_id;
    logic [1:0]        r_evt_type;
    logic              r_evt_valid;
    logic              r_evt_drop;

    logic [N_BTN-1:0]  w_rot;
    logic              w_any;
    int                w_pos;
    logic [c_ID_W-1:0] w_sel;
    logic [1:0]        w_sel_type;

    always_comb begin
        w_any = 1'b0;
        w_pos = 0;
        w_rot = N_BTN'({w_pend_flag, w_pend_flag} >> r_ptr);
        for (int k = N_BTN - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_any = 1'b1;
                w_pos = k;
            end
        end
        w_pos = w_pos + int'(r_ptr);
        if (w_pos >= N_BTN) begin
            w_pos = w_pos - N_BTN;
        end
        w_sel = c_ID_W'(w_pos);
    end

    always_comb begin
        w_sel_type  = 2'b00;
        w_latch_vec = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (w_sel == c_ID_W'(i)) begin
                w_sel_type     = w_pend_type[2*i +: 2];
                w_latch_vec[i] = (r_fsm == c_ST_IDLE) && w_any;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Offer FSM. Returning to IDLE after every handshake gives the guaranteed
    // one-cycle bubble between consecutive events.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= c_ST_IDLE;
            r_ptr       <= '0;
            r_evt_id    <= '0;
            r_evt_type  <= 2'b00;
            r_evt_valid <= 1'b0;
        end else begin
            case (r_fsm)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_evt_id    <= w_sel;
                        r_evt_type  <= w_sel_type;
                        r_evt_valid <= 1'b1;
                        r_fsm       <= c_ST_OFFER;
                    end
                end
                c_ST_OFFER: begin
                    if (evt_ready) begin
                        r_evt_valid <= 1'b0;
                        r_ptr       <= (r_evt_id == c_ID_LAST) ? '0 : r_evt_id + c_ID_W'(1);
                        r_fsm       <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_evt_valid <= 1'b0;
                    r_fsm       <= c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt_drop <= 1'b0;
        end else begin
            r_evt_drop <= |w_drop_vec;
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;
    assign evt_type  = r_evt_type;
    assign evt_drop  = r_evt_drop;

endmodule
`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_event_arbiter
//  Purpose  : Self-checking bench for button_event_arbiter. Directed scenarios
//             followed by randomized button activity, all compared each cycle
//             against a behavioural model. Honours LONGPRESS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_button_event_arbiter;

    localparam int N = 4;
    localparam int D = 8;
    localparam int L = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_state;
    logic         evt_valid;
    logic         evt_ready;
    logic [1:0]   evt_id;
    logic [1:0]   evt_type;
    logic         evt_drop;

    always #5 clk = ~clk;

    button_event_arbiter #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_state(btn_state),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_id   (evt_id),
        .evt_type (evt_type),
        .evt_drop (evt_drop)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model.
    //   * m_hist holds raw samples, bit k = sample taken k edges ago; the
    //     synchronizer makes the design see bit 2.
    //   * A button flips when its last D synced samples all disagree with the
    //     debounced level.
    //   * A flip becomes a pending event one edge later; long-press after L
    //     edges of steady press.
    //   * Pending slots are served round-robin, one handshake per offer.
    // ------------------------------------------------------------------------
    logic [31:0] m_hist [N];
    bit          m_st   [N];
    bit          m_chg  [N];
    int          m_hold [N];
    bit          m_pf   [N];
    int          m_pt   [N];
    bit          m_off;
    int          m_id, m_type, m_ptr;
    bit          m_drop;

    int obs_id[$];
    int obs_ty[$];
    int n_drops;

    task automatic model_edge(input bit r, input logic [N-1:0] rw, input bit rdy);
        int          lat;
        bit          ld;
        int          t;
        logic [31:0] win;
        logic [31:0] mask;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_hist[i] = 0; m_st[i] = 0; m_chg[i] = 0; m_hold[i] = 0;
                m_pf[i] = 0; m_pt[i] = 0;
            end
            m_off = 0; m_id = 0; m_type = 0; m_ptr = 0; m_drop = 0;
            return;
        end
        lat = -1;
        if (m_off) begin
            if (rdy) begin
                m_off = 0;
                m_ptr = (m_id + 1) % N;
            end
        end else begin
            for (int k = N - 1; k >= 0; k--)
                if (m_pf[(m_ptr + k) % N]) lat = (m_ptr + k) % N;
            if (lat >= 0) begin
                m_off  = 1;
                m_id   = lat;
                m_type = m_pt[lat];
            end
        end
        m_drop = 0;
        for (int i = 0; i < N; i++) begin
            ld = 0;
            t  = 0;
            if (m_chg[i]) begin
                ld = 1;
                t  = m_st[i] ? 0 : 1;
            end
            if (m_st[i]) m_hold[i]++;
            else         m_hold[i] = 0;
`ifdef LONGPRESS_EN
            if (m_hold[i] == L) begin
                ld = 1;
                t  = 2;
            end
`endif
            if (ld) begin
                if (m_pf[i] && lat != i) m_drop = 1;
                m_pf[i] = 1;
                m_pt[i] = t;
            end else if (lat == i) begin
                m_pf[i] = 0;
            end
        end
        mask = (32'd1 << D) - 32'd1;
        for (int i = 0; i < N; i++) begin
            m_hist[i] = {m_hist[i][30:0], rw[i]};
            win       = (m_hist[i] >> 2) & mask;
            m_chg[i]  = 0;
            if (win == (m_st[i] ? 32'd0 : mask)) begin
                m_st[i]  = ~m_st[i];
                m_chg[i] = 1;
            end
        end
    endtask

    // One clock: apply edge to model, then compare outputs 1 time unit later.
    task automatic step();
        bit           hs;
        bit           r;
        logic [N-1:0] exp_st;
        hs = evt_valid && evt_ready;
        r  = rst;
        @(posedge clk);
        model_edge(r, btn_raw, evt_ready);
        #1;
        for (int i = 0; i < N; i++) exp_st[i] = m_st[i];
        chk("btn_state", 32'(btn_state), 32'(exp_st));
        chk("evt_valid", 32'(evt_valid), 32'(m_off));
        if (m_off) begin
            chk("evt_id",   32'(evt_id),   m_id);
            chk("evt_type", 32'(evt_type), m_type);
        end
        chk("evt_drop", 32'(evt_drop), 32'(m_drop));
        if (hs && !r) begin
            obs_id.push_back(int'(evt_id));
            obs_ty.push_back(int'(evt_type));
        end
        if (evt_drop) n_drops++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_obs();
        obs_id.delete();
        obs_ty.delete();
        n_drops = 0;
    endtask

    initial begin
        int cnt;
        int exp_t[$];
        int rate;

        rst       = 1'b1;
        btn_raw   = '0;
        evt_ready = 1'b1;
        n_drops   = 0;
        run(3);
        chk("rst_state", 32'(btn_state), 0);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_id",    32'(evt_id),    0);
        chk("rst_type",  32'(evt_type),  0);
        chk("rst_drop",  32'(evt_drop),  0);
        rst = 1'b0;
        run(2);

        // 1: single clean press, latency and one event
        clear_obs();
        btn_raw[1] = 1'b1;
        cnt = 0;
        while (cnt < 40 && !btn_state[1]) begin
            step();
            cnt++;
        end
        chk("t1_latency", cnt, 10);
        run(10);
        chk("t1_nevt", obs_id.size(), 1);
        if (obs_id.size() == 1) begin
            chk("t1_id",   obs_id[0], 1);
            chk("t1_type", obs_ty[0], 0);
        end

        // 2: bouncing input then steady press
        clear_obs();
        for (int c = 0; c < 30; c++) begin
            if (c % 3 == 0) btn_raw[0] = ~btn_raw[0];
            step();
        end
        btn_raw[0] = 1'b1;
        run(20);
        chk("t2_nevt", obs_id.size(), 1);
        if (obs_id.size() == 1) begin
            chk("t2_id",   obs_id[0], 0);
            chk("t2_type", obs_ty[0], 0);
        end
        chk("t2_drops", n_drops, 0);

        // 3: all buttons together, from a fresh pointer
        btn_raw = '0;
        rst     = 1'b1;
        run(2);
        rst = 1'b0;
        run(3);
        clear_obs();
        btn_raw = 4'hF;
        run(30);
        chk("t3p_nevt", obs_id.size(), 4);
        if (obs_id.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk("t3p_id",   obs_id[i], i);
                chk("t3p_type", obs_ty[i], 0);
            end
        clear_obs();
        btn_raw = 4'h0;
        run(30);
        chk("t3r_nevt", obs_id.size(), 4);
        if (obs_id.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk("t3r_id",   obs_id[i], i);
                chk("t3r_type", obs_ty[i], 1);
            end

        // 4: stalled consumer, release overwritten by the next press
        clear_obs();
        evt_ready  = 1'b0;
        btn_raw[2] = 1'b1;
        run(16);
        btn_raw[2] = 1'b0;
        run(16);
        btn_raw[2] = 1'b1;
        run(16);
        chk("t4_held_valid", 32'(evt_valid), 1);
        evt_ready = 1'b1;
        run(10);
        chk("t4_nevt", obs_id.size(), 2);
        if (obs_id.size() == 2)
            for (int i = 0; i < 2; i++) begin
                chk("t4_id",   obs_id[i], 2);
                chk("t4_type", obs_ty[i], 0);
            end
        chk("t4_drops", n_drops, 1);

        // 5: reset while offering
        btn_raw = '0;
        run(20);
        evt_ready  = 1'b0;
        btn_raw[0] = 1'b1;
        cnt = 0;
        while (cnt < 30 && !evt_valid) begin
            step();
            cnt++;
        end
        chk("t5_offer", 32'(evt_valid), 1);
        rst     = 1'b1;
        btn_raw = '0;
        step();
        chk("t5_valid", 32'(evt_valid), 0);
        chk("t5_state", 32'(btn_state), 0);
        rst = 1'b0;
        clear_obs();
        evt_ready = 1'b1;
        run(30);
        chk("t5_nevt", obs_id.size(), 0);

        // 6: long hold
        clear_obs();
        btn_raw[1] = 1'b1;
        run(60);
        btn_raw[1] = 1'b0;
        run(20);
`ifdef LONGPRESS_EN
        exp_t = '{0, 2, 1};
`else
        exp_t = '{0, 1};
`endif
        chk("t6_nevt", obs_id.size(), exp_t.size());
        if (obs_id.size() == exp_t.size())
            for (int i = 0; i < exp_t.size(); i++) begin
                chk("t6_id",   obs_id[i], 1);
                chk("t6_type", obs_ty[i], exp_t[i]);
            end

        // Randomized activity with varying bounce rates and stalls
        rate = 16;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) rate = ($urandom_range(0, 1) == 0) ? 4 : 40;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, rate - 1) == 0) btn_raw[i] = ~btn_raw[i];
            evt_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 1499) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
